// File: rtl/regfile_ctx_if.sv
// Memory-side port of the register-file context sequencer: one outstanding
// request, held until mem_ack, with restore data returned alongside the ack.
interface regfile_ctx_mem_if #(
    parameter int WIDTH = 16
);
    logic             mem_req;
    logic             mem_we;
    logic [15:0]      mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/regfile_ctx.sv
// Byte-enabled register file with two bypassed read ports and a sequencer
// that streams every register to or from memory for context save/restore.
module regfile_ctx #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_sel,
    input  logic [WIDTH/8-1:0]   i_wr_be,
    input  logic [WIDTH-1:0]     i_wr_data,
    output logic                 o_wr_stall,
    input  logic [AW-1:0]        i_rd_a_sel,
    input  logic [AW-1:0]        i_rd_b_sel,
    output logic [WIDTH-1:0]     o_rd_a_data,
    output logic [WIDTH-1:0]     o_rd_b_data,
    input  logic                 i_ctx_save,
    input  logic                 i_ctx_restore,
    input  logic [15:0]          i_ctx_base,
    regfile_ctx_mem_if.master    mem,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int            NB   = WIDTH / 8;
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SAVE, S_RESTORE} state_t;

    state_t                         r_state, w_state_nxt;
    logic [NREGS-1:0][WIDTH-1:0]    r_regs;
    logic [15:0]                    r_base;
    logic [AW-1:0]                  r_idx;
    logic                           r_done;

    logic                           w_idle;
    logic                           w_wr;
    logic                           w_start;
    logic                           w_ack;
    logic                           w_last_ack;

    function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] old_d,
                                                 input logic [WIDTH-1:0] new_d,
                                                 input logic [NB-1:0]    be);
        logic [WIDTH-1:0] res;
        res = old_d;
        for (int k = 0; k < NB; k++)
            if (be[k]) res[8*k +: 8] = new_d[8*k +: 8];
        return res;
    endfunction

    assign w_idle     = (r_state == S_IDLE);
    assign w_wr       = i_wr_en && w_idle;
    assign w_start    = w_idle && (i_ctx_save || i_ctx_restore);
    // An ack only counts while a request is actually outstanding.
    assign w_ack      = mem.mem_ack && !w_idle;
    assign w_last_ack = w_ack && (r_idx == LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_ctx_save)         w_state_nxt = S_SAVE;
                else if (i_ctx_restore) w_state_nxt = S_RESTORE;
            end
            S_SAVE, S_RESTORE: begin
                if (w_last_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last_ack;
            if (w_start) begin
                r_base <= i_ctx_base;
                r_idx  <= '0;
            end else if (w_ack && !w_last_ack) begin
                r_idx <= r_idx + AW'(1);
            end
        end
    end

    // External writes and restore loads never coincide: one is IDLE-only.
    always_ff @(posedge clk) begin
        if (rst)
            r_regs <= '0;
        else if (w_wr)
            r_regs[i_wr_sel] <= f_merge(r_regs[i_wr_sel], i_wr_data, i_wr_be);
        else if (r_state == S_RESTORE && w_ack)
            r_regs[r_idx] <= mem.mem_rdata;
    end

    logic [1:0][AW-1:0]    w_rd_sel;
    logic [1:0][WIDTH-1:0] w_rd_data;

    assign w_rd_sel = {i_rd_b_sel, i_rd_a_sel};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            w_rd_data[p] = r_regs[w_rd_sel[p]];
            if (w_wr && (i_wr_sel == w_rd_sel[p]))
                w_rd_data[p] = f_merge(r_regs[w_rd_sel[p]], i_wr_data, i_wr_be);
        end
    end

    assign o_rd_a_data = w_rd_data[0];
    assign o_rd_b_data = w_rd_data[1];

    assign o_busy        = !w_idle;
    assign o_wr_stall    = !w_idle;
    assign o_done        = r_done;
    assign mem.mem_req   = !w_idle;
    assign mem.mem_we    = (r_state == S_SAVE);
    assign mem.mem_addr  = w_idle ? 16'h0000 : r_base + 16'(r_idx);
    assign mem.mem_wdata = (r_state == S_SAVE) ? r_regs[r_idx] : '0;
endmodule

// File: tb/tb_regfile_ctx.sv
// Directed bench: stimulus pushes expectations into queues, a negedge monitor
// (which also plays the memory) pops and compares whenever the DUT presents data.
module tb_regfile_ctx;
    localparam int W  = 16;
    localparam int NR = 8;
    localparam int AW = 3;

    typedef struct packed {logic we; logic [15:0] addr; logic [15:0] wdata;} mem_t;
    typedef struct packed {logic [15:0] a; logic [15:0] b;} rd_t;
    typedef struct packed {logic busy, done, req, we, stall; logic [15:0] addr, wdata;} st_t;
    typedef struct packed {int busy; int nreq;} seq_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_sel = '0;
    logic [1:0]    wr_be = '0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_stall;
    logic [AW-1:0] rd_a_sel = '0, rd_b_sel = '0;
    logic [W-1:0]  rd_a_data, rd_b_data;
    logic          ctx_save = 1'b0, ctx_restore = 1'b0;
    logic [15:0]   ctx_base = '0;
    logic          busy, done;

    regfile_ctx_mem_if #(.WIDTH(W)) mem ();

    regfile_ctx #(.WIDTH(W), .NREGS(NR)) dut (
        .clk(clk), .rst(rst),
        .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_be(wr_be), .i_wr_data(wr_data),
        .o_wr_stall(wr_stall),
        .i_rd_a_sel(rd_a_sel), .i_rd_b_sel(rd_b_sel),
        .o_rd_a_data(rd_a_data), .o_rd_b_data(rd_b_data),
        .i_ctx_save(ctx_save), .i_ctx_restore(ctx_restore), .i_ctx_base(ctx_base),
        .mem(mem.master),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    mem_t mem_q[$];
    rd_t  rd_q[$];
    st_t  st_q[$];
    seq_t seq_q[$];

    logic rd_chk = 1'b0, st_chk = 1'b0, fin_req = 1'b0, fin_ack = 1'b0;
    int   ack_wait = 0;
    int   checks = 0, errors = 0;
    int   ack_tot = 0, done_tot = 0;
    int   seq_busy = 0, seq_req = 0, wcnt = 0, acnt = 0;
    logic in_req = 1'b0;

    // ---------------- monitor / memory model ----------------
    always @(negedge clk) begin
        if (st_chk) begin
            st_t e, a;
            a = '{busy, done, mem.mem_req, mem.mem_we, wr_stall, mem.mem_addr, mem.mem_wdata};
            checks++;
            if (st_q.size() == 0) begin
                errors++; $display("FAIL status: no expectation queued");
            end else begin
                e = st_q.pop_front();
                if (a !== e) begin
                    errors++; $display("FAIL status act=%h exp=%h", a, e);
                end
            end
        end
        if (rd_chk) begin
            rd_t e;
            if (rd_q.size() == 0) begin
                checks++; errors++; $display("FAIL read: no expectation queued");
            end else begin
                e = rd_q.pop_front();
                checks++;
                if (rd_a_data !== e.a) begin
                    errors++; $display("FAIL rd_a sel=%0d act=%h exp=%h", rd_a_sel, rd_a_data, e.a);
                end
                checks++;
                if (rd_b_data !== e.b) begin
                    errors++; $display("FAIL rd_b sel=%0d act=%h exp=%h", rd_b_sel, rd_b_data, e.b);
                end
            end
        end
        if (rst) begin
            mem.mem_ack = 1'b0; mem.mem_rdata = '0;
            seq_busy = 0; seq_req = 0; wcnt = 0; acnt = 0; in_req = 1'b0;
        end else begin
            if (busy) seq_busy++;
            if (mem.mem_req) begin
                if (!in_req) begin
                    mem_t e;
                    seq_req++; in_req = 1'b1; wcnt = 0;
                    checks++;
                    if (mem_q.size() == 0) begin
                        errors++; $display("FAIL mem_req unexpected addr=%h we=%0d", mem.mem_addr, mem.mem_we);
                    end else begin
                        e = mem_q.pop_front();
                        if (mem.mem_we !== e.we || mem.mem_addr !== e.addr ||
                            (e.we && mem.mem_wdata !== e.wdata)) begin
                            errors++;
                            $display("FAIL mem_req act we=%0d addr=%h wdata=%h exp we=%0d addr=%h wdata=%h",
                                     mem.mem_we, mem.mem_addr, mem.mem_wdata, e.we, e.addr, e.wdata);
                        end
                    end
                end
                if (wcnt >= ack_wait) begin
                    mem.mem_ack = 1'b1; mem.mem_rdata = 16'h5A00 + 16'(acnt);
                    acnt++; ack_tot++; in_req = 1'b0;
                end else begin
                    mem.mem_ack = 1'b0; wcnt++;
                end
            end else begin
                mem.mem_ack = 1'b0; acnt = 0; in_req = 1'b0;
            end
            if (done) begin
                seq_t e;
                done_tot++;
                checks++;
                if (seq_q.size() == 0) begin
                    errors++; $display("FAIL done: unexpected pulse");
                end else begin
                    e = seq_q.pop_front();
                    if (seq_busy != e.busy || seq_req != e.nreq) begin
                        errors++;
                        $display("FAIL sequence act busy=%0d reqs=%0d exp busy=%0d reqs=%0d",
                                 seq_busy, seq_req, e.busy, e.nreq);
                    end
                end
                seq_busy = 0; seq_req = 0;
            end
        end
        if (fin_req && !fin_ack) begin
            checks++;
            if (mem_q.size() != 0) begin
                errors++; $display("FAIL mem_q leftover act=%0d exp=0", mem_q.size());
            end
            checks++;
            if (seq_q.size() != 0) begin
                errors++; $display("FAIL done_missing leftover act=%0d exp=0", seq_q.size());
            end
            fin_ack = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
        wr_en = 1'b0; ctx_save = 1'b0; ctx_restore = 1'b0; rd_chk = 1'b0; st_chk = 1'b0;
    endtask

    task automatic wr(input int sel, input logic [1:0] be, input logic [15:0] d);
        wr_en = 1'b1; wr_sel = AW'(sel); wr_be = be; wr_data = d;
    endtask

    task automatic rd_expect(input int sa, input int sb, input logic [15:0] ea, input logic [15:0] eb);
        rd_a_sel = AW'(sa); rd_b_sel = AW'(sb);
        rd_q.push_back('{ea, eb}); rd_chk = 1'b1;
    endtask

    task automatic wait_done();
        int snap;
        snap = done_tot;
        for (int i = 0; i < 400 && done_tot == snap; i++) tick();
        if (done_tot == snap) begin
            $display("FAIL timeout waiting for done act=%0d exp=%0d", done_tot, snap + 1);
            $fatal(1, "timeout");
        end
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        st_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0}); st_chk = 1'b1;
        rd_expect(0, 7, 16'h0, 16'h0);
        tick();

        // byte-enabled writes
        wr(3, 2'b11, 16'hABCD); tick();
        wr(3, 2'b10, 16'h1200); tick();
        for (int i = 0; i < 4; i++) begin
            rd_expect(i, i + 4, (i == 3) ? 16'h12CD : 16'h0, 16'h0); tick();
        end

        // bypass on both ports
        wr(5, 2'b11, 16'h00FF); tick();
        wr(5, 2'b01, 16'h3344); rd_expect(5, 5, 16'h0044, 16'h0044); tick();
        rd_expect(5, 5, 16'h0044, 16'h0044); tick();

        // save with two wait states per request
        for (int i = 0; i < NR; i++) begin
            wr(i, 2'b11, 16'h1000 + 16'(i)); tick();
        end
        ack_wait = 2;
        for (int i = 0; i < NR; i++) mem_q.push_back('{1'b1, 16'h0200 + 16'(i), 16'h1000 + 16'(i)});
        seq_q.push_back('{24, 8});
        ctx_base = 16'h0200; ctx_save = 1'b1; tick();
        st_q.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0200, 16'h1000}); st_chk = 1'b1;
        wait_done();

        // restore across the 16-bit address wrap, with a stalled write
        ack_wait = 0;
        for (int i = 0; i < NR; i++) mem_q.push_back('{1'b0, 16'hFFFC + 16'(i), 16'h0});
        seq_q.push_back('{8, 8});
        ctx_base = 16'hFFFC; ctx_restore = 1'b1; tick();
        tick(); tick();
        wr(0, 2'b11, 16'hFFFF); rd_expect(0, 0, 16'h5A00, 16'h5A00); tick();
        wait_done();
        for (int i = 0; i < 4; i++) begin
            rd_expect(i, i + 4, 16'h5A00 + 16'(i), 16'h5A04 + 16'(i)); tick();
        end

        // save wins over restore; restore mid-save ignored
        for (int i = 0; i < NR; i++) mem_q.push_back('{1'b1, 16'h0100 + 16'(i), 16'h5A00 + 16'(i)});
        seq_q.push_back('{8, 8});
        ctx_base = 16'h0100; ctx_save = 1'b1; ctx_restore = 1'b1; tick();
        tick();
        ctx_base = 16'h0800; ctx_restore = 1'b1; tick();
        wait_done();
        for (int i = 0; i < 12; i++) tick();

        // reset after the third ack of a restore
        for (int i = 0; i < 3; i++) mem_q.push_back('{1'b0, 16'h0000 + 16'(i), 16'h0});
        begin
            int snap;
            snap = ack_tot;
            ctx_base = 16'h0000; ctx_restore = 1'b1; tick();
            for (int i = 0; i < 50 && ack_tot - snap < 3; i++) tick();
            if (ack_tot - snap < 3) begin
                $display("FAIL timeout waiting for acks act=%0d exp=3", ack_tot - snap);
                $fatal(1, "timeout");
            end
        end
        rst = 1'b1; tick();
        rst = 1'b0;
        st_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0}); st_chk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_expect(i, i + 4, 16'h0, 16'h0); tick();
        end
        for (int i = 0; i < 4; i++) tick();

        fin_req = 1'b1;
        for (int i = 0; i < 5 && !fin_ack; i++) tick();
        if (!fin_ack) begin
            $display("FAIL final check not reached act=0 exp=1");
            $fatal(1, "timeout");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
